// File: rtl/paddle_move.sv
// Two-player paddle controller: synchronized, debounced buttons step each paddle centre on a
// periodic movement tick, clamped to [Y_MIN, Y_MAX]. Define PADDLE_AI_EN to drive the right paddle from ballY.
module paddle_move #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MOVE_DIV        = 100000,
  parameter int unsigned STEP            = 4,
  parameter int unsigned Y_MIN           = 95,
  parameter int unsigned Y_MAX           = 455,
  parameter int unsigned Y_START         = 275
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnUpL,
  input  logic       btnDnL,
  input  logic       btnUpR,
  input  logic       btnDnR,
`ifdef PADDLE_AI_EN
  input  logic [9:0] ballY,
`endif
  output logic [9:0] yposLeft,
  output logic [9:0] yposRight
);

  localparam int unsigned NB   = 4;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef enum logic [1:0] {DIR_IDLE, DIR_UP, DIR_DOWN} dir_e;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync2_q;
  logic [NB-1:0]   db_q;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [TK_W-1:0] tick_cnt_q;
  logic            tick_c;
  logic            req_up_r, req_dn_r;
  dir_e            dir_l_q, dir_r_q;
  logic [9:0]      y_l_q, y_r_q, y_l_d, y_r_d;

  // bit order: {DnR, UpR, DnL, UpL}
  assign btn_raw = {btnDnR, btnUpR, btnDnL, btnUpL};

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: accept a change only after it has persisted long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Free-running movement tick
  assign tick_c = (tick_cnt_q == TK_W'(MOVE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)       tick_cnt_q <= '0;
    else if (tick_c) tick_cnt_q <= '0;
    else             tick_cnt_q <= tick_cnt_q + TK_W'(1);
  end

`ifdef PADDLE_AI_EN
  assign req_up_r = (ballY < y_r_q);
  assign req_dn_r = (ballY > y_r_q);
`else
  assign req_up_r = db_q[2];
  assign req_dn_r = db_q[3];
`endif

  function automatic dir_e decide(input logic up, input logic dn);
    dir_e d;
    d = DIR_IDLE;
    if (up && !dn)      d = DIR_UP;
    else if (dn && !up) d = DIR_DOWN;
    return d;
  endfunction

  // Clamped step at 11 bits so the subtraction can never wrap
  function automatic logic [9:0] next_y(input logic [9:0] y, input dir_e d);
    logic [10:0] y_ext, r;
    y_ext = {1'b0, y};
    r     = y_ext;
    case (d)
      DIR_UP:   r = (y_ext < 11'(Y_MIN) + 11'(STEP)) ? 11'(Y_MIN) : y_ext - 11'(STEP);
      DIR_DOWN: r = (y_ext + 11'(STEP) > 11'(Y_MAX)) ? 11'(Y_MAX) : y_ext + 11'(STEP);
      default:  r = y_ext;
    endcase
    return r[9:0];
  endfunction

  always_comb begin
    y_l_d = y_l_q;
    y_r_d = y_r_q;
    if (tick_c) begin
      y_l_d = next_y(y_l_q, dir_l_q);
      y_r_d = next_y(y_r_q, dir_r_q);
    end
  end

  // Direction FSMs and paddle position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_l_q <= DIR_IDLE;
      dir_r_q <= DIR_IDLE;
      y_l_q   <= 10'(Y_START);
      y_r_q   <= 10'(Y_START);
    end else begin
      dir_l_q <= decide(db_q[0], db_q[1]);
      dir_r_q <= decide(req_up_r, req_dn_r);
      y_l_q   <= y_l_d;
      y_r_q   <= y_r_d;
    end
  end

  assign yposLeft  = y_l_q;
  assign yposRight = y_r_q;

endmodule
